// File: rtl/conv_pool_layer_scheduler_if.sv
// Control and strobe bundle between the conv/pool layer scheduler and its neighbours.
// The master modport is the scheduler side. The slave modport is the layer FSM / datapath side.
interface conv_pool_layer_scheduler_if #(
  parameter int AW  = 9,
  parameter int WAW = 10,
  parameter int OAW = 13
) ();
  logic           iSTART;
  logic           iHOLD;
  logic           oRD_EN;
  logic [AW-1:0]  oRD_ADDR;
  logic [WAW-1:0] oW_ADDR;
  logic           oACC_EN;
  logic           oACC_CLR;
  logic           oPOOL_EN;
  logic           oPOOL_CLR;
  logic           oWR_EN;
  logic [OAW-1:0] oWR_ADDR;
  logic           oBUSY;
  logic           oDONE;

  modport master (
    input  iSTART, iHOLD,
    output oRD_EN, oRD_ADDR, oW_ADDR, oACC_EN, oACC_CLR, oPOOL_EN, oPOOL_CLR,
           oWR_EN, oWR_ADDR, oBUSY, oDONE
  );
  modport slave (
    output iSTART, iHOLD,
    input  oRD_EN, oRD_ADDR, oW_ADDR, oACC_EN, oACC_CLR, oPOOL_EN, oPOOL_CLR,
           oWR_EN, oWR_ADDR, oBUSY, oDONE
  );
endinterface

// File: rtl/conv_pool_layer_scheduler.sv
// Address and strobe sequencer for one 3x3 conv + 2x2 max-pool layer pass.
// Loop nest, innermost first: tap, pool position, channel, column, row.
module conv_pool_layer_scheduler #(
  parameter int WIDTH  = 14,
  parameter int HEIGHT = 18,
  parameter int NCH    = 112,
  parameter int RD_LAT = 2,
  parameter int AW     = 9,
  parameter int WAW    = 10,
  parameter int OAW    = 13
) (
  input  logic iCLK,
  input  logic iRST,
  conv_pool_layer_scheduler_if.master bus
);
  localparam int OW     = (WIDTH - 2) / 2;
  localparam int OH     = (HEIGHT - 2) / 2;
  localparam int STAGES = RD_LAT;
  localparam int KW     = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int IW     = (OW > 1) ? $clog2(OW) : 1;
  localparam int JW     = (OH > 1) ? $clog2(OH) : 1;
  localparam int DW     = $clog2(RD_LAT + 3);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e          state_q, state_d;
  logic [3:0]      t_q, t_d;
  logic [1:0]      p_q, p_d;
  logic [KW-1:0]   k_q, k_d;
  logic [IW-1:0]   i_q, i_d;
  logic [JW-1:0]   j_q, j_d;
  logic [DW-1:0]   dcnt_q, dcnt_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic            issue, last;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;
  logic [WAW-1:0]  w_addr_q, w_addr_d;
  logic            acc_clr_d, pool_en_d, pool_clr_d, wr_en_d;
  logic [OAW-1:0]  wr_addr_d;
  int unsigned     ti, pi, ki, ii, ji;

  // Bit 0 of every sideband pipe is the cycle oRD_EN is high. Later stages follow the fixed read latency.
  logic [STAGES:0]             vld_pipe_q;
  logic [RD_LAT:0]             aclr_pipe_q;
  logic [RD_LAT+1:0]           pen_pipe_q, pclr_pipe_q;
  logic [RD_LAT+2:0]           wen_pipe_q;
  logic [RD_LAT+2:0][OAW-1:0]  wadr_pipe_q;

  assign issue = !bus.iHOLD && (state_q == RUN || (state_q == IDLE && bus.iSTART));

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    p_d     = p_q;
    k_d     = k_q;
    i_d     = i_q;
    j_d     = j_q;
    dcnt_d  = dcnt_q;
    last    = 1'b0;
    if (issue) begin
      if (t_q == 4'd8) begin
        t_d = '0;
        if (p_q == 2'd3) begin
          p_d = '0;
          if (k_q == KW'(NCH - 1)) begin
            k_d = '0;
            if (i_q == IW'(OW - 1)) begin
              i_d = '0;
              if (j_q == JW'(OH - 1)) begin
                j_d  = '0;
                last = 1'b1;
              end else j_d = j_q + 1'b1;
            end else i_d = i_q + 1'b1;
          end else k_d = k_q + 1'b1;
        end else p_d = p_q + 1'b1;
      end else t_d = t_q + 1'b1;
    end
    unique case (state_q)
      IDLE:  if (bus.iSTART) state_d = RUN;
      RUN:   if (last) begin
               state_d = DRAIN;
               dcnt_d  = '0;
             end
      DRAIN: if (dcnt_q == DW'(RD_LAT + 2)) state_d = DONE;
             else dcnt_d = dcnt_q + 1'b1;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  // Sideband fields stay zero for idle slots, so no strobe can appear without an issue behind it.
  always_comb begin
    ti         = 32'(t_q);
    pi         = 32'(p_q);
    ki         = 32'(k_q);
    ii         = 32'(i_q);
    ji         = 32'(j_q);
    rd_addr_d  = '0;
    w_addr_d   = '0;
    acc_clr_d  = 1'b0;
    pool_en_d  = 1'b0;
    pool_clr_d = 1'b0;
    wr_en_d    = 1'b0;
    wr_addr_d  = '0;
    if (issue) begin
      rd_addr_d  = AW'((2*ii + (pi & 1) + ti % 3) + (2*ji + (pi >> 1) + ti / 3) * WIDTH);
      w_addr_d   = WAW'(ki*9 + ti);
      acc_clr_d  = (t_q == 4'd0);
      pool_en_d  = (t_q == 4'd8);
      pool_clr_d = (t_q == 4'd8) && (p_q == 2'd0);
      wr_en_d    = (t_q == 4'd8) && (p_q == 2'd3);
      if (wr_en_d) wr_addr_d = OAW'(ki*OW*OH + ji*OW + ii);
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= IDLE;
      t_q         <= '0;
      p_q         <= '0;
      k_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      dcnt_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_addr_q   <= '0;
      w_addr_q    <= '0;
      vld_pipe_q  <= '0;
      aclr_pipe_q <= '0;
      pen_pipe_q  <= '0;
      pclr_pipe_q <= '0;
      wen_pipe_q  <= '0;
      wadr_pipe_q <= '0;
    end else begin
      state_q     <= state_d;
      t_q         <= t_d;
      p_q         <= p_d;
      k_q         <= k_d;
      i_q         <= i_d;
      j_q         <= j_d;
      dcnt_q      <= dcnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      rd_addr_q   <= rd_addr_d;
      w_addr_q    <= w_addr_d;
      vld_pipe_q  <= {vld_pipe_q[STAGES-1:0], issue};
      aclr_pipe_q <= {aclr_pipe_q[RD_LAT-1:0], acc_clr_d};
      pen_pipe_q  <= {pen_pipe_q[RD_LAT:0], pool_en_d};
      pclr_pipe_q <= {pclr_pipe_q[RD_LAT:0], pool_clr_d};
      wen_pipe_q  <= {wen_pipe_q[RD_LAT+1:0], wr_en_d};
      wadr_pipe_q <= {wadr_pipe_q[RD_LAT+1:0], wr_addr_d};
    end
  end

  assign bus.oRD_EN    = vld_pipe_q[0];
  assign bus.oRD_ADDR  = rd_addr_q;
  assign bus.oW_ADDR   = w_addr_q;
  assign bus.oACC_EN   = vld_pipe_q[STAGES];
  assign bus.oACC_CLR  = aclr_pipe_q[RD_LAT];
  assign bus.oPOOL_EN  = pen_pipe_q[RD_LAT+1];
  assign bus.oPOOL_CLR = pclr_pipe_q[RD_LAT+1];
  assign bus.oWR_EN    = wen_pipe_q[RD_LAT+2];
  assign bus.oWR_ADDR  = wadr_pipe_q[RD_LAT+2];
  assign bus.oBUSY     = busy_q;
  assign bus.oDONE     = done_q;
endmodule
